// File: rtl/jstk_spi_master.sv
// SPI mode-0 master that polls a PmodJSTK: sends {6'b100000, led} plus four
// dummy bytes, and packs the five received bytes into jstkData.
//
// Ports:
//   clk, rst       system clock, synchronous active-high reset
//   start          poll request, accepted only while idle
//   led[1:0]       LED bits placed in the command byte, latched on accept
//   miso           serial data from the joystick
//   ss, sclk, mosi SPI pins (ss active-low, sclk idle low, mosi MSB first)
//   jstkData[39:0] last complete response, first byte in [39:32]
//   busy           high from the cycle after accept through the done cycle
//   done           one-cycle pulse when jstkData has just been updated
module jstk_spi_master #(
    parameter int HALF_SCLK_CYCLES = 50,
    parameter int SS_SETUP_CYCLES  = 1500,
    parameter int INTERBYTE_CYCLES = 1000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [1:0]  led,
    input  logic        miso,
    output logic        ss,
    output logic        sclk,
    output logic        mosi,
    output logic [39:0] jstkData,
    output logic        busy,
    output logic        done
);

    localparam int MAX_A = (HALF_SCLK_CYCLES > SS_SETUP_CYCLES) ?
                           HALF_SCLK_CYCLES : SS_SETUP_CYCLES;
    localparam int MAX_C = (MAX_A > INTERBYTE_CYCLES) ?
                           MAX_A : INTERBYTE_CYCLES;
    localparam int CW    = $clog2(MAX_C + 1);

    localparam logic [CW-1:0] HALF_LAST  = CW'(HALF_SCLK_CYCLES - 1);
    localparam logic [CW-1:0] SETUP_LAST = CW'(SS_SETUP_CYCLES - 1);
    localparam logic [CW-1:0] GAP_LAST   = CW'(INTERBYTE_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_SHIFT,
        S_GAP,
        S_DONE
    } state_t;

    state_t        r_state, w_state_nxt;
    logic [CW-1:0] r_cnt,   w_cnt_nxt;
    logic [2:0]    r_bit,   w_bit_nxt;
    logic [2:0]    r_byte,  w_byte_nxt;
    logic [7:0]    r_tx,    w_tx_nxt;
    logic [7:0]    r_rx,    w_rx_nxt;
    logic [39:0]   r_acc,   w_acc_nxt;
    logic [39:0]   r_data,  w_data_nxt;
    logic          r_sclk,  w_sclk_nxt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_bit   <= '0;
            r_byte  <= '0;
            r_tx    <= '0;
            r_rx    <= '0;
            r_acc   <= '0;
            r_data  <= '0;
            r_sclk  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_bit   <= w_bit_nxt;
            r_byte  <= w_byte_nxt;
            r_tx    <= w_tx_nxt;
            r_rx    <= w_rx_nxt;
            r_acc   <= w_acc_nxt;
            r_data  <= w_data_nxt;
            r_sclk  <= w_sclk_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_bit_nxt   = r_bit;
        w_byte_nxt  = r_byte;
        w_tx_nxt    = r_tx;
        w_rx_nxt    = r_rx;
        w_acc_nxt   = r_acc;
        w_data_nxt  = r_data;
        w_sclk_nxt  = r_sclk;

        unique case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_state_nxt = S_SETUP;
                    w_tx_nxt    = {6'b100000, led};
                    w_byte_nxt  = '0;
                    w_bit_nxt   = '0;
                    w_cnt_nxt   = '0;
                    w_sclk_nxt  = 1'b0;
                    w_acc_nxt   = '0;
                end
            end
            S_SETUP: begin
                if (r_cnt == SETUP_LAST) begin
                    w_cnt_nxt   = '0;
                    w_state_nxt = S_SHIFT;
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            S_SHIFT: begin
                if (r_cnt != HALF_LAST) begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end else begin
                    w_cnt_nxt = '0;
                    if (!r_sclk) begin
                        // rising edge: capture miso
                        w_sclk_nxt = 1'b1;
                        w_rx_nxt   = {r_rx[6:0], miso};
                    end else begin
                        // falling edge: advance mosi
                        w_sclk_nxt = 1'b0;
                        w_tx_nxt   = {r_tx[6:0], 1'b0};
                        if (r_bit != 3'd7) begin
                            w_bit_nxt = r_bit + 1'b1;
                        end else begin
                            w_bit_nxt = '0;
                            w_acc_nxt = {r_acc[31:0], r_rx};
                            if (r_byte != 3'd4) begin
                                w_byte_nxt  = r_byte + 1'b1;
                                w_tx_nxt    = 8'h00;
                                w_state_nxt = S_GAP;
                            end else begin
                                // publish whole word at once
                                w_data_nxt  = {r_acc[31:0], r_rx};
                                w_state_nxt = S_DONE;
                            end
                        end
                    end
                end
            end
            S_GAP: begin
                if (r_cnt == GAP_LAST) begin
                    w_cnt_nxt   = '0;
                    w_state_nxt = S_SHIFT;
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            S_DONE: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_comb begin
        ss   = 1'b1;
        mosi = 1'b0;
        busy = 1'b0;
        done = 1'b0;
        unique case (r_state)
            S_IDLE: begin
            end
            S_SETUP, S_SHIFT, S_GAP: begin
                ss   = 1'b0;
                mosi = r_tx[7];
                busy = 1'b1;
            end
            S_DONE: begin
                busy = 1'b1;
                done = 1'b1;
            end
            default: begin
            end
        endcase
    end

    assign sclk     = r_sclk;
    assign jstkData = r_data;

endmodule

// File: tb/tb_jstk_spi_master.sv
// Testbench for jstk_spi_master: vector table, hand-written corner cases
// and randomized polls against a joystick slave model.
module tb_jstk_spi_master;

    localparam int H   = 2;
    localparam int S   = 4;
    localparam int G   = 3;
    localparam int LAT = 1 + S + 80 * H + 4 * G;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [1:0]  led;
    logic        miso;
    logic        ss;
    logic        sclk;
    logic        mosi;
    logic [39:0] jstkData;
    logic        busy;
    logic        done;

    always #5 clk = ~clk;

    jstk_spi_master #(
        .HALF_SCLK_CYCLES(H),
        .SS_SETUP_CYCLES (S),
        .INTERBYTE_CYCLES(G)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .led     (led),
        .miso    (miso),
        .ss      (ss),
        .sclk    (sclk),
        .mosi    (mosi),
        .jstkData(jstkData),
        .busy    (busy),
        .done    (done)
    );

    int n_chk  = 0;
    int n_fail = 0;

    logic [39:0] slv_word = '0;
    logic [39:0] mosi_cap;
    int slv_k;
    int first_low;
    int gap_low;
    int bad_ph;
    int ss_viol;
    int done_cnt;

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Joystick slave + pin monitor. miso holds the next response bit
    // while sclk is low and is scrambled while sclk is high.
    initial begin
        logic ss_q;
        logic sclk_q;
        int   run;
        int   exp_low;
        ss_q = 1'b1; sclk_q = 1'b0; run = 0;
        slv_k = 0; mosi_cap = '0; first_low = -1; gap_low = -1;
        bad_ph = 0; ss_viol = 0; done_cnt = 0; miso = 1'b0;
        forever begin
            @(negedge clk);
            if (ss === 1'b1 && sclk === 1'b1) ss_viol++;
            if (done === 1'b1) done_cnt++;
            if (ss === 1'b0) begin
                if (ss_q === 1'b1) begin
                    slv_k = 0; mosi_cap = '0; first_low = -1;
                    gap_low = -1; bad_ph = 0; run = 1;
                end else if (sclk === sclk_q) begin
                    run++;
                end else if (sclk === 1'b1) begin
                    if (slv_k == 0) exp_low = S + H;
                    else if (slv_k % 8 == 0) exp_low = G + H;
                    else exp_low = H;
                    if (slv_k == 0) first_low = run;
                    else if (slv_k % 8 == 0) gap_low = run;
                    if (run != exp_low) bad_ph++;
                    mosi_cap = {mosi_cap[38:0], mosi};
                    slv_k++;
                    run = 1;
                end else begin
                    if (run != H) bad_ph++;
                    run = 1;
                end
            end
            if (sclk === 1'b1 || slv_k >= 40) miso = 1'($urandom);
            else miso = slv_word[39 - slv_k];
            ss_q = ss;
            sclk_q = sclk;
        end
    end

    task automatic poll(input logic [1:0] l, input logic [39:0] rsp,
                        input logic [7:0] ecmd, input logic [39:0] edata,
                        input int glitch_at);
        int n;
        int d0;
        slv_word = rsp;
        led = l;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        n = 1;
        d0 = done_cnt;
        chk("busy_after_accept", 64'(busy), 64'(1));
        chk("ss_after_accept", 64'(ss), 64'(0));
        while (done !== 1'b1 && n < LAT + 50) begin
            @(negedge clk);
            n++;
            start = (n == glitch_at);
            if (n == glitch_at) led = ~l;
        end
        start = 1'b0;
        chk("done_latency", 64'(n), 64'(LAT));
        chk("jstkData", 64'(jstkData), 64'(edata));
        chk("ss_in_done", 64'(ss), 64'(1));
        chk("busy_in_done", 64'(busy), 64'(1));
        chk("mosi_bytes", 64'(mosi_cap), 64'({ecmd, 32'h0}));
        chk("sclk_rises", 64'(slv_k), 64'(40));
        chk("setup_low", 64'(first_low), 64'(S + H));
        chk("gap_low", 64'(gap_low), 64'(G + H));
        chk("phase_errors", 64'(bad_ph), 64'(0));
        @(negedge clk);
        chk("done_width", 64'(done), 64'(0));
        chk("busy_cleared", 64'(busy), 64'(0));
        @(negedge clk);
        chk("done_count", 64'(done_cnt - d0), 64'(1));
    endtask

    typedef struct {
        logic [1:0]  led;
        logic [39:0] rsp;
        logic [7:0]  cmd;
        logic [39:0] data;
        int          glitch;
    } vec_t;

    vec_t vt[5];

    initial begin
        int n;
        int gap;
        int d0;
        logic [1:0]  l;
        logic [39:0] rsp;

        vt[0] = '{2'b01, 40'hA5023C0106, 8'h81, 40'hA5023C0106, 0};
        vt[1] = '{2'b01, 40'hA5023C0106, 8'h81, 40'hA5023C0106, 50};
        vt[2] = '{2'b00, 40'hFFFFFFFFFF, 8'h80, 40'hFFFFFFFFFF, 0};
        vt[3] = '{2'b11, 40'h0000000000, 8'h83, 40'h0000000000, 120};
        vt[4] = '{2'b10, 40'h5AC3813C7E, 8'h82, 40'h5AC3813C7E, 0};

        rst = 1'b1;
        start = 1'b0;
        led = 2'b00;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        chk("rst_ss", 64'(ss), 64'(1));
        chk("rst_sclk", 64'(sclk), 64'(0));
        chk("rst_mosi", 64'(mosi), 64'(0));
        chk("rst_busy", 64'(busy), 64'(0));
        chk("rst_done", 64'(done), 64'(0));
        chk("rst_data", 64'(jstkData), 64'(0));
        repeat (20) @(negedge clk);
        chk("idle_ss", 64'(ss), 64'(1));
        chk("idle_busy", 64'(busy), 64'(0));
        chk("idle_data", 64'(jstkData), 64'(0));
        chk("idle_no_done", 64'(done_cnt), 64'(0));

        for (int i = 0; i < 5; i++) begin
            poll(vt[i].led, vt[i].rsp, vt[i].cmd, vt[i].data,
                 vt[i].glitch);
            repeat (2) @(negedge clk);
        end

        // start held high: back-to-back polls
        slv_word = 40'h1122334455;
        led = 2'b10;
        start = 1'b1;
        n = 0;
        while (done !== 1'b1 && n < LAT + 50) begin
            @(negedge clk);
            n++;
        end
        chk("cont_latency1", 64'(n), 64'(LAT));
        chk("cont_cmd1", 64'(mosi_cap), 64'({8'h82, 32'h0}));
        chk("cont_data1", 64'(jstkData), 64'(40'h1122334455));
        slv_word = 40'h66778899AA;
        gap = 0;
        @(negedge clk);
        while (ss === 1'b1 && gap < 10) begin
            gap++;
            @(negedge clk);
        end
        chk("cont_idle_gap", 64'(gap), 64'(1));
        n = 1;
        while (done !== 1'b1 && n < LAT + 50) begin
            @(negedge clk);
            n++;
        end
        start = 1'b0;
        chk("cont_latency2", 64'(n), 64'(LAT));
        chk("cont_cmd2", 64'(mosi_cap), 64'({8'h82, 32'h0}));
        chk("cont_data2", 64'(jstkData), 64'(40'h66778899AA));
        repeat (3) @(negedge clk);
        chk("cont_stopped", 64'(busy), 64'(0));

        // reset during byte 3
        slv_word = 40'hDEADBEEF42;
        led = 2'b01;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        n = 0;
        while (slv_k < 18 && n < LAT + 50) begin
            @(negedge clk);
            n++;
        end
        chk("reached_byte3", 64'(slv_k >= 18 && slv_k < 24), 64'(1));
        d0 = done_cnt;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("mid_rst_ss", 64'(ss), 64'(1));
        chk("mid_rst_sclk", 64'(sclk), 64'(0));
        chk("mid_rst_mosi", 64'(mosi), 64'(0));
        chk("mid_rst_busy", 64'(busy), 64'(0));
        chk("mid_rst_done", 64'(done), 64'(0));
        chk("mid_rst_data", 64'(jstkData), 64'(0));
        repeat (LAT + 20) @(negedge clk);
        chk("mid_rst_no_done", 64'(done_cnt - d0), 64'(0));
        poll(2'b01, 40'h0F1E2D3C4B, 8'h81, 40'h0F1E2D3C4B, 0);

        // randomized polls: command = 0x80 | led, data = slave response
        for (int i = 0; i < 6; i++) begin
            l = 2'($urandom_range(0, 3));
            rsp = {8'($urandom), 32'($urandom)};
            poll(l, rsp, 8'h80 | {6'b0, l}, rsp,
                 (i % 2 == 1) ? int'($urandom_range(2, LAT - 1)) : 0);
            repeat ($urandom_range(1, 5)) @(negedge clk);
        end

        chk("sclk_high_with_ss_high", 64'(ss_viol), 64'(0));
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
